fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Instruction-fetch stage that produces the InstrF/PCF/PCPlus4F bundle consumed by the IF/ID pipeline register. Owns the architectural PC and issues one-outstanding-request fetches to instruction memory over a valid/ready request and valid-only response channel. Honours StallF from the hazard unit, applies PCSrcE/PCTargetE redirects from Execute, and reports when no valid instruction is present so the hazard unit can clear IF/ID.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction driven on InstrF when no valid fetch is held (addi x0,x0,0)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
StallF  in  1  hazard unit holds the fetch stage; the held instruction is not consumed
PCSrcE  in  1  redirect request from Execute (taken branch/jump)
PCTargetE  in  32  redirect target; bits [1:0] forced to 0
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  32  fetch address, word aligned
imem_rsp_valid  in  1  response data valid (exactly one per accepted request, latency >=1 cycle)
imem_rsp_data  in  32  fetched instruction word
InstrF  out  32  instruction to IF/ID
PCF  out  32  PC of InstrF / outstanding fetch
PCPlus4F  out  32  PCF + 4, modulo 2^32
FetchValidF  out  1  InstrF holds a real fetched instruction
FetchBusyF  out  1  ~FetchValidF; hazard unit uses it to clear IF/ID

Behaviour:
- Reset (async, any state, mid-transaction included): state IDLE, PC=RESET_PC, instr buffer=NOP_INSTR, imem_req_valid=0, FetchValidF=0, FetchBusyF=1, PCF=RESET_PC, PCPlus4F=RESET_PC+4. An in-flight response arriving after reset deassert is not expected; memory is reset together with this block.
- PCF = PC register; PCPlus4F = PC+4 combinational, wraps 32'hFFFF_FFFC -> 0.
- InstrF = buffer when FetchValidF=1, else NOP_INSTR.
- imem_req_valid=1 only in REQ; imem_req_addr = PC.
- States and transitions (redirect = PCSrcE; on redirect PC <= {PCTargetE[31:2],2'b00}):
  IDLE: next cycle -> REQ. Redirect: update PC, -> REQ.
  REQ: ready=1 -> WAIT. Redirect & ready=1 -> DRAIN (accepted request is stale). Redirect & ready=0 -> stay REQ; address retargets next cycle (unaccepted requests may change address; memory contract).
  WAIT: rsp_valid=1 -> buffer <= rsp_data, HOLD. Redirect (with or without rsp_valid) -> response dropped; with rsp_valid -> REQ, without -> DRAIN.
  DRAIN: wait for stale response; rsp_valid=1 -> drop, -> REQ. Redirect in DRAIN: update PC, stay DRAIN (still one stale response owed).
  HOLD: FetchValidF=1. StallF=1 -> stay, InstrF/PCF stable. StallF=0 -> instruction consumed this edge, PC <= PC+4, -> REQ. Redirect -> held instruction discarded, -> REQ (redirect beats StallF).
- Priority: reset > redirect > StallF > normal progress.
- StallF ignored outside HOLD (nothing to consume); PC never advances except on consume or redirect.
- Never more than one accepted-but-unanswered request. rsp_valid in IDLE/REQ/HOLD is a protocol error; ignored.
- Minimum throughput: one instruction per 3 cycles with single-cycle memory (REQ, WAIT, HOLD).

Decomposition:
- Shared pipeline package: NOP_INSTR constant, fetch state encoding (IDLE, REQ, WAIT, DRAIN, HOLD), RESET_PC default.
- No sub-module; single FSM plus PC and instruction buffer registers.

Test Plan:
- Reset then zero-wait memory returning 32'h00500093 at 0x0 -> req at 0x0 in cycle 1, FetchValidF=1 with InstrF=32'h00500093, PCF=0, PCPlus4F=4 in cycle 3; next req addr 0x4.
- HOLD with StallF=1 for 4 cycles -> InstrF/PCF unchanged, no new request; StallF=0 -> next req at PC+4.
- Redirect in WAIT to 0x100 with response 2 cycles later -> DRAIN, stale word never on InstrF, next req addr 0x100, PCF=0x100.
- Redirect to 0x203 with imem_req_ready=0 in REQ -> imem_req_addr becomes 0x200 next cycle, exactly one request accepted.
- Redirect to 0x40 and StallF=1 same cycle in HOLD -> held instruction dropped, FetchValidF=0, InstrF=NOP_INSTR, req at 0x40.
- PC=0xFFFF_FFFC consumed -> PCPlus4F=0 while held, next req addr 0x0; reset asserted in WAIT -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_pkg
// Description : Shared pipeline definitions for the instruction-fetch stage:
//               fetch FSM state encoding, NOP instruction and reset PC.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_unit_pkg;

    // addi x0, x0, 0 - driven whenever no real instruction is held
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

    // Architectural PC after reset
    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;

    // Fetch FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,   // out of reset, no request yet
        ST_REQ   = 3'd1,   // request presented to instruction memory
        ST_WAIT  = 3'd2,   // request accepted, waiting for its response
        ST_DRAIN = 3'd3,   // accepted request went stale, swallow its response
        ST_HOLD  = 3'd4    // valid instruction held for the decode stage
    } fetch_state_t;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch stage. Owns the PC, issues one outstanding
//               fetch at a time over a valid/ready request channel and a
//               valid-only response channel, honours StallF and Execute
//               redirects, and presents InstrF/PCF/PCPlus4F to IF/ID.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic        FetchValidF,
    output logic        FetchBusyF
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr;

    logic [31:0]  w_redirect_pc;
    logic [31:0]  w_pc_plus4;

    // Redirect targets are forced onto a word boundary
    assign w_redirect_pc = PCTargetE & 32'hFFFF_FFFC;
    // Sequential next PC; wraps naturally at 2^32
    assign w_pc_plus4    = r_pc + 32'd4;

    // Fetch FSM, PC and instruction buffer; redirect has priority over StallF
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (PCSrcE) begin
                        r_pc <= w_redirect_pc;
                    end
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (PCSrcE) begin
                        // An accepted request now targets the wrong PC
                        r_pc <= w_redirect_pc;
                        if (imem_req_ready) begin
                            r_state <= ST_DRAIN;
                        end
                    end else if (imem_req_ready) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (PCSrcE) begin
                        r_pc    <= w_redirect_pc;
                        // If the response is here it is dropped now, otherwise drain it
                        r_state <= imem_rsp_valid ? ST_REQ : ST_DRAIN;
                    end else if (imem_rsp_valid) begin
                        r_instr <= imem_rsp_data;
                        r_state <= ST_HOLD;
                    end
                end
                ST_DRAIN: begin
                    if (PCSrcE) begin
                        r_pc <= w_redirect_pc;
                    end
                    if (imem_rsp_valid) begin
                        r_state <= ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (PCSrcE) begin
                        r_pc    <= w_redirect_pc;
                        r_state <= ST_REQ;
                    end else if (!StallF) begin
                        r_pc    <= w_pc_plus4;
                        r_state <= ST_REQ;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req_valid = (r_state == ST_REQ);
    assign imem_req_addr  = r_pc;
    assign FetchValidF    = (r_state == ST_HOLD);
    assign FetchBusyF     = ~FetchValidF;
    assign InstrF         = FetchValidF ? r_instr : NOP_INSTR;
    assign PCF            = r_pc;
    assign PCPlus4F       = w_pc_plus4;

endmodule : fetch_unit
`default_nettype wire
